inst_fetch_unit: RTL and testbench

INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

---
 rtl/inst_fetch_unit.sv | 106 ++++++++++
 tb/tb_inst_fetch_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: keeps the PC, fetches on a same-cycle cache hit and
// fills a circular instruction queue. Define IFU_STATIC_PREDICT_EN to follow JAL and backward branches.
module inst_fetch_unit #(
  parameter int          IQ_DEPTH = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic [31:0] pc,
  output logic        inst_req,
  input  logic        inst_ready,
  input  logic [31:0] inst_res,
  input  logic        flush_in,
  input  logic [31:0] flush_pc,
  output logic        iq_valid,
  output logic [31:0] iq_inst,
  output logic [31:0] iq_pc,
  output logic        iq_pred_taken,
  input  logic        iq_deq
);
  localparam int PW = $clog2(IQ_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
  } iq_entry_t;

  iq_entry_t     iq_mem [IQ_DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic          full;
  logic          fetch_fire, deq_fire, flush_fire;
  logic [31:0]   next_pc;
  logic          pred_bit;

  assign full     = (count == CW'(IQ_DEPTH));
  assign inst_req = !rst_in && !flush_in && !full;
  assign iq_valid = (count != '0);

  // flush_in already blocks inst_req, so a flush cycle never fetches
  assign fetch_fire = rdy_in && inst_req && inst_ready;
  assign deq_fire   = rdy_in && iq_deq && iq_valid && !flush_in && !rst_in;
  assign flush_fire = rdy_in && flush_in;

`ifdef IFU_STATIC_PREDICT_EN
  logic [31:0] j_imm, b_imm;

  assign j_imm = {{12{inst_res[31]}}, inst_res[19:12], inst_res[20], inst_res[30:21], 1'b0};
  assign b_imm = {{20{inst_res[31]}}, inst_res[7], inst_res[30:25], inst_res[11:8], 1'b0};

  // JAL always taken; conditional branches taken only when backward
  always_comb begin
    next_pc  = pc + 32'd4;
    pred_bit = 1'b0;
    if (inst_res[6:0] == 7'b1101111) begin
      next_pc  = pc + j_imm;
      pred_bit = 1'b1;
    end else if (inst_res[6:0] == 7'b1100011 && inst_res[31]) begin
      next_pc  = pc + b_imm;
      pred_bit = 1'b1;
    end
  end
`else
  assign next_pc  = pc + 32'd4;
  assign pred_bit = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pc    <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_fire) begin
      pc    <= flush_pc;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (fetch_fire) begin
        pc   <= next_pc;
        tail <= tail + PW'(1);
      end
      if (deq_fire)
        head <= head + PW'(1);
      if (fetch_fire && !deq_fire)
        count <= count + CW'(1);
      else if (deq_fire && !fetch_fire)
        count <= count - CW'(1);
    end
  end

  // entry storage carries no reset; contents are only observed while valid
  always_ff @(posedge clk_in) begin
    if (fetch_fire)
      iq_mem[tail] <= '{inst: inst_res, pc: pc, pred: pred_bit};
  end

  assign iq_inst       = iq_mem[head].inst;
  assign iq_pc         = iq_mem[head].pc;
  assign iq_pred_taken = iq_mem[head].pred;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios plus randomized traffic checked
// each cycle against a queue-based reference model.
module tb_inst_fetch_unit;
  localparam int          DEPTH = 8;
  localparam logic [31:0] RPC   = 32'h0;

  logic        clk_in, rst_in, rdy_in, inst_ready, flush_in, iq_deq;
  logic [31:0] inst_res, flush_pc, pc, iq_inst, iq_pc;
  logic        inst_req, iq_valid, iq_pred_taken;

  inst_fetch_unit #(.IQ_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .pc(pc), .inst_req(inst_req),
    .inst_ready(inst_ready), .inst_res(inst_res), .flush_in(flush_in), .flush_pc(flush_pc),
    .iq_valid(iq_valid), .iq_inst(iq_inst), .iq_pc(iq_pc), .iq_pred_taken(iq_pred_taken),
    .iq_deq(iq_deq)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mpc;
  bit          known = 0;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {pred, next_pc} from the static-prediction rules, immediates rebuilt arithmetically
  function automatic logic [32:0] predict(input logic [31:0] w, input logic [31:0] p);
    int   off;
    logic pr;
    off = 4;
    pr  = 1'b0;
`ifdef IFU_STATIC_PREDICT_EN
    if (w[6:0] == 7'h6F) begin
      off = int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2
            - (w[31] ? 1048576 : 0);
      pr  = 1'b1;
    end else if (w[6:0] == 7'h63 && w[31]) begin
      off = int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2 - 4096;
      pr  = 1'b1;
    end
`endif
    return {pr, p + 32'(off)};
  endfunction

  // one cycle: drive at negedge, check combinational outputs, advance model, clock
  task automatic step(input logic rs, input logic en, input logic hit, input logic [31:0] res,
                      input logic fl, input logic [31:0] fpc, input logic dq);
    logic [32:0] pn;
    bit          do_deq, do_fire;
    rst_in = rs; rdy_in = en; inst_ready = hit; inst_res = res;
    flush_in = fl; flush_pc = fpc; iq_deq = dq;
    #1;
    if (known || rs)
      chk("inst_req", {31'b0, inst_req}, {31'b0, !rs && !fl && (q.size() < DEPTH)});
    if (known) begin
      chk("pc", pc, mpc);
      chk("iq_valid", {31'b0, iq_valid}, {31'b0, q.size() != 0});
      if (q.size() != 0) begin
        chk("iq_inst", iq_inst, q[0].inst);
        chk("iq_pc", iq_pc, q[0].pc);
        chk("iq_pred", {31'b0, iq_pred_taken}, {31'b0, q[0].pred});
      end
    end
    if (rs) begin
      q.delete();
      mpc   = RPC;
      known = 1;
    end else if (known && en) begin
      if (fl) begin
        q.delete();
        mpc = fpc;
      end else begin
        do_deq  = dq && q.size() != 0;
        do_fire = hit && q.size() < DEPTH;
        if (do_deq) void'(q.pop_front());
        if (do_fire) begin
          pn = predict(res, mpc);
          q.push_back('{inst: res, pc: mpc, pred: pn[32]});
          mpc = pn[31:0];
        end
      end
    end
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic settle();
    rst_in = 0; flush_in = 0; inst_ready = 0; iq_deq = 0; rdy_in = 1;
    #1;
  endtask

  task automatic fire_n(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 1, 32'h13, 0, 0, 0);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: return 32'h0000_0013;
      1: return r;
      2: return {r[31:7], 7'b1101111};
      default: return {1'b1, r[30:7], 7'b1100011};
    endcase
  endfunction

  initial begin
    rst_in = 1; rdy_in = 0; inst_ready = 0; inst_res = 0; flush_in = 0; flush_pc = 0; iq_deq = 0;
    @(negedge clk_in);

    // reset then three hits
    step(1, 0, 0, 0, 1, 32'hdead, 0);
    fire_n(3);
    settle();
    chk("r037_pc", pc, 32'hC);
    chk("r037_head_pc", iq_pc, 32'h0);
    chk("r037_valid", {31'b0, iq_valid}, 32'h1);

    // fill to full, one dequeue reopens a slot the following cycle
    fire_n(5);
    settle();
    chk("r038_req_full", {31'b0, inst_req}, 32'h0);
    chk("r038_pc_full", pc, 32'h20);
    step(0, 1, 1, 32'h13, 0, 0, 1);
    settle();
    chk("r038_req_after_deq", {31'b0, inst_req}, 32'h1);
    chk("r038_pc_hold", pc, 32'h20);
    step(0, 1, 1, 32'h13, 0, 0, 0);
    settle();
    chk("r038_pc_refill", pc, 32'h24);
    chk("r038_req_refull", {31'b0, inst_req}, 32'h0);
    chk("r038_head_pc", iq_pc, 32'h4);

    // flush dominates fetch and dequeue
    step(1, 1, 0, 0, 0, 0, 0);
    fire_n(4);
    step(0, 1, 1, 32'h13, 1, 32'h100, 1);
    settle();
    chk("r039_valid", {31'b0, iq_valid}, 32'h0);
    chk("r039_pc", pc, 32'h100);

    // backward branch prediction
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 32'h10, 0);
    step(0, 1, 1, 32'hFE000EE3, 0, 0, 0);
    settle();
    chk("r040_head_pc", iq_pc, 32'h10);
`ifdef IFU_STATIC_PREDICT_EN
    chk("r040_pc", pc, 32'h0C);
    chk("r040_pred", {31'b0, iq_pred_taken}, 32'h1);
`else
    chk("r040_pc", pc, 32'h14);
    chk("r040_pred", {31'b0, iq_pred_taken}, 32'h0);
`endif

    // rdy_in low freezes everything
    step(1, 1, 0, 0, 0, 0, 0);
    fire_n(3);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 32'h13, 0, 0, 1);
    settle();
    chk("r041_pc", pc, 32'hC);
    chk("r041_head_pc", iq_pc, 32'h0);
    chk("r041_valid", {31'b0, iq_valid}, 32'h1);
    step(0, 1, 1, 32'h13, 0, 0, 1);
    settle();
    chk("r041_resume_pc", pc, 32'h10);
    chk("r041_resume_head", iq_pc, 32'h4);

    // long miss at 0x40
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 32'h40, 0);
    for (int i = 0; i < 20; i++) step(0, 1, 0, $urandom, 0, 0, 0);
    settle();
    chk("r042_pc_hold", pc, 32'h40);
    chk("r042_req", {31'b0, inst_req}, 32'h1);
    step(0, 1, 1, 32'h00A00093, 0, 0, 0);
    settle();
    chk("r042_head_pc", iq_pc, 32'h40);
    chk("r042_head_inst", iq_inst, 32'h00A00093);
    chk("r042_pc", pc, 32'h44);
    step(0, 1, 0, 0, 0, 0, 1);
    settle();
    chk("r042_single", {31'b0, iq_valid}, 32'h0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7,
           rand_word(), $urandom_range(0, 39) == 0, $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 9) < (i % 400 < 200 ? 3 : 7));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
